// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: iterative signed-binary to BCD converter (shift-add-3).
// Captures a signed value and reduces it to sign and magnitude. It runs one
// double-dabble iteration per clock and then holds the sign, the digits and
// an overflow flag until the consumer takes them.
// Optional feature macro: BCD_SAT_EN. When it is defined, an overflowing
// magnitude is reported as all-9s. When it is undefined, the top digit is
// dropped.
module bcd_seq_conv #(
    parameter int DATA_W = 11,
    parameter int NDIG   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [4*NDIG-1:0] out_bcd,
    output logic              out_ovf
);

    localparam int SCR_D = NDIG + 1;          // one extra digit keeps the overflow carry
    localparam int SCR_W = 4 * SCR_D;
    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [SCR_W-1:0]   scr_r;
    logic [SCR_W-1:0]   scr_next_s;
    logic [DATA_W-1:0]  mag_r;
    logic [DATA_W-1:0]  mag_next_s;
    logic [DATA_W-1:0]  mag_in_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               sign_r;
    logic               last_s;
    logic [BCD_W-1:0]   res_bcd_s;
    logic               res_ovf_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               out_sign_r;
    logic [BCD_W-1:0]   out_bcd_r;
    logic               out_ovf_r;

    // One BCD digit correction: digits of 5 or more get +3 before the shift.
    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Apply the digit correction to every scratch digit.
    function automatic logic [SCR_W-1:0] adjust(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        r = '0;
        for (int i = 0; i < SCR_D; i++) begin
            r[4*i +: 4] = add3(s[4*i +: 4]);
        end
        return r;
    endfunction

    // Magnitude of the incoming value. The most-negative input maps to 2^(DATA_W-1) without wrapping.
    always_comb begin
        mag_in_s = in_data;
        if (in_data[DATA_W-1]) begin
            mag_in_s = ~in_data + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            mag_in_s = in_data;
        end
    end

    // One double-dabble step: correct digits, then shift {scratch, magnitude} left.
    always_comb begin
        scr_next_s = '0;
        mag_next_s = '0;
        {scr_next_s, mag_next_s} = {adjust(scr_r), mag_r} << 1;
    end

    // Final result taken from the scratch value that the last iteration produces.
    always_comb begin
        last_s    = (cnt_r == CNT_W'(1));
        res_ovf_s = |scr_next_s[SCR_W-1 -: 4];
        res_bcd_s = scr_next_s[BCD_W-1:0];
`ifdef BCD_SAT_EN
        if (res_ovf_s) begin
            res_bcd_s = {NDIG{4'h9}};
        end else begin
            res_bcd_s = scr_next_s[BCD_W-1:0];
        end
`else
        res_bcd_s = scr_next_s[BCD_W-1:0];
`endif
    end

    // Next-state logic for the accept / iterate / hold sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, iteration counter and registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            scr_r       <= '0;
            mag_r       <= '0;
            cnt_r       <= '0;
            sign_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sign_r  <= 1'b0;
            out_bcd_r   <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_data[DATA_W-1];
                        mag_r  <= mag_in_s;
                        scr_r  <= '0;
                        cnt_r  <= CNT_W'(DATA_W);
                    end
                end
                SHIFT: begin
                    scr_r <= scr_next_s;
                    mag_r <= mag_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_s) begin
                        out_bcd_r  <= res_bcd_s;
                        out_sign_r <= sign_r;
                        out_ovf_r  <= res_ovf_s;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sign  = out_sign_r;
    assign out_bcd   = out_bcd_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: directed bench for bcd_seq_conv with a decimal-arithmetic
// reference model and a per-cycle result comparator.
module tb_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_data = 11'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [11:0] out_bcd;
    logic        out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic        model_valid = 1'b0;
    logic        model_sign  = 1'b0;
    logic [11:0] model_bcd   = 12'h000;
    logic        model_ovf   = 1'b0;

    bcd_seq_conv #(.DATA_W(11), .NDIG(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of |v| using integer arithmetic.
    task automatic model(input int v, output logic s, output logic [11:0] b, output logic o);
        int m;
        s = (v < 0);
        m = (v < 0) ? -v : v;
        o = (m > 999);
`ifdef BCD_SAT_EN
        if (o) m = 999;
`endif
        m = m % 1000;
        b = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endtask

    // Per-cycle comparator: while a result is presented, it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("model_pending", 32'(model_valid), 32'd1);
            check("model_sign", 32'(out_sign), 32'(model_sign));
            check("model_bcd", 32'(out_bcd), 32'(model_bcd));
            check("model_ovf", 32'(out_ovf), 32'(model_ovf));
            check("ready_low_in_done", 32'(in_ready), 32'd0);
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Present one value, check latency and hand-computed result; leaves the DUT in DONE.
    task automatic convert(input int v, input logic [11:0] eb, input logic es, input logic eo,
                           input string name);
        int lat;
        wait_ready();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 11'(v);
        model(v, model_sign, model_bcd, model_ovf);
        model_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd11);
        check({name, "_sign"}, 32'(out_sign), 32'(es));
        check({name, "_bcd"}, 32'(out_bcd), 32'(eb));
        check({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_valid = 1'b0;
        check("consume_valid_low", 32'(out_valid), 32'd0);
        check("consume_ready_high", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [11:0] e1000;
        logic [11:0] e1024;
        logic [11:0] e1023;
        int          seen;
`ifdef BCD_SAT_EN
        e1000 = 12'h999;
        e1024 = 12'h999;
        e1023 = 12'h999;
`else
        e1000 = 12'h000;
        e1024 = 12'h024;
        e1023 = 12'h023;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sign", 32'(out_sign), 32'd0);
        check("rst_out_bcd", 32'(out_bcd), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);

        convert(0, 12'h000, 1'b0, 1'b0, "zero");        consume();
        convert(999, 12'h999, 1'b0, 1'b0, "p999");      consume();
        convert(1000, e1000, 1'b0, 1'b1, "p1000");      consume();
        convert(-1024, e1024, 1'b1, 1'b1, "m1024");     consume();
        convert(1023, e1023, 1'b0, 1'b1, "p1023");      consume();
        convert(-1, 12'h001, 1'b1, 1'b0, "m1");         consume();
        convert(5, 12'h005, 1'b0, 1'b0, "p5");          consume();

        // Hold the result with out_ready low while upstream keeps offering data.
        convert(-457, 12'h457, 1'b1, 1'b0, "m457");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 11'd77;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_bcd", 32'(out_bcd), 32'h457);
            check("hold_sign", 32'(out_sign), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready   = 1'b0;
        model_valid = 1'b0;
        check("release_valid_low", 32'(out_valid), 32'd0);
        check("release_ready_high", 32'(in_ready), 32'd1);
        check("idle_keeps_bcd", 32'(out_bcd), 32'h457);
        check("idle_keeps_sign", 32'(out_sign), 32'd1);

        // Reset while a result is pending in DONE.
        convert(-999, 12'h999, 1'b1, 1'b0, "m999");
        @(negedge clk);
        rst = 1'b1;
        model_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done_valid", 32'(out_valid), 32'd0);
        check("rst_done_ready", 32'(in_ready), 32'd1);
        check("rst_done_bcd", 32'(out_bcd), 32'd0);
        check("rst_done_sign", 32'(out_sign), 32'd0);

        // Reset during the fifth iteration cycle.
        wait_ready();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 11'd555;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_shift_valid", 32'(out_valid), 32'd0);
        check("rst_shift_ready", 32'(in_ready), 32'd1);
        check("rst_shift_bcd", 32'(out_bcd), 32'd0);
        check("rst_shift_sign", 32'(out_sign), 32'd0);
        check("rst_shift_ovf", 32'(out_ovf), 32'd0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_shift_no_result", 32'(seen), 32'd0);
        convert(321, 12'h321, 1'b0, 1'b0, "p321");      consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
